// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the rVProc core.
// Owns the PC, drives the combinational instruction memory and registers the
// returned word into the IF/ID pipeline register. It handles stall,
// branch/jump redirect and an ECALL/EBREAK halt.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   imem_addr         word address to instruction memory (pc[ADDR_W+1:2])
//   imem_data         instruction for imem_addr, valid in the same cycle
//   stall             hold PC and IF/ID
//   redirect_valid    taken branch/jump; redirect_target is the new PC
//   pc                current fetch PC
//   if_id_pc/_pc4     PC of the registered instruction, and that PC + 4
//   if_id_inst/_valid registered instruction; valid=0 marks a bubble
//   halted            stage is parked after an ECALL/EBREAK
//   fetch_count       number of instructions captured with valid=1
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_pc4,
  output logic [31:0]       if_id_inst,
  output logic              if_id_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n, if_id_pc_n, if_id_pc4_n, if_id_inst_n, fetch_count_n;
  logic        if_id_valid_n;
  logic        is_sys;

  // Redirect targets are word aligned; the low two bits are dropped.
  logic        unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^redirect_target[1:0];

  // Upper PC bits are not decoded, so the memory aliases.
  assign imem_addr = pc[ADDR_W+1:2];
  assign halted    = (state == HALT);
  assign is_sys    = (imem_data == ECALL) || (imem_data == EBREAK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_pc    <= 32'd0;
      if_id_pc4   <= 32'd4;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_pc    <= if_id_pc_n;
      if_id_pc4   <= if_id_pc4_n;
      if_id_inst  <= if_id_inst_n;
      if_id_valid <= if_id_valid_n;
      fetch_count <= fetch_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    if_id_pc_n    = if_id_pc;
    if_id_pc4_n   = if_id_pc4;
    if_id_inst_n  = if_id_inst;
    if_id_valid_n = if_id_valid;
    fetch_count_n = fetch_count;
    if (redirect_valid) begin
      // Redirect wins over stall and also pulls the stage out of HALT, which
      // covers an older mispredict resolving after a wrong-path ECALL.
      pc_n          = {redirect_target[31:2], 2'b00};
      if_id_inst_n  = NOP_INST;
      if_id_valid_n = 1'b0;
      state_n       = RUN;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if_id_pc_n    = pc;
          if_id_pc4_n   = pc + 32'd4;
          if_id_inst_n  = imem_data;
          if_id_valid_n = 1'b1;
          fetch_count_n = fetch_count + 32'd1;
          // The system instruction itself is delivered; fetch then parks.
          if (is_sys) state_n = HALT;
          else        pc_n    = pc + 32'd4;
        end
        HALT: begin
          if_id_inst_n  = NOP_INST;
          if_id_valid_n = 1'b0;
        end
        default: state_n = RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk, rst, stall, redirect_valid;
  logic [31:0] redirect_target, imem_data;
  logic [5:0]  imem_addr;
  logic [31:0] pc, if_id_pc, if_id_pc4, if_id_inst, fetch_count;
  logic        if_id_valid, halted;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr];

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .pc(pc), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_inst(if_id_inst),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural view of the stage.
  logic [31:0] m_pc, m_ipc, m_inst, m_cnt;
  logic        m_valid, m_halt;

  task automatic m_reset();
    m_pc = 32'd0; m_ipc = 32'd0; m_inst = NOP; m_valid = 1'b0;
    m_cnt = 32'd0; m_halt = 1'b0;
  endtask

  task automatic m_step();
    logic [31:0] w;
    w = mem[m_pc[7:2]];
    if (redirect_valid) begin
      m_pc = redirect_target & 32'hFFFF_FFFC;
      m_inst = NOP; m_valid = 1'b0; m_halt = 1'b0;
    end else if (stall) begin
      // everything held
    end else if (m_halt) begin
      m_inst = NOP; m_valid = 1'b0;
    end else begin
      m_ipc = m_pc; m_inst = w; m_valid = 1'b1; m_cnt = m_cnt + 1;
      if (w == ECALL || w == EBREAK) m_halt = 1'b1;
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    pc,          m_pc);
    chk({tag, ".addr"},  {26'd0, imem_addr}, {26'd0, m_pc[7:2]});
    chk({tag, ".ipc"},   if_id_pc,    m_ipc);
    chk({tag, ".ipc4"},  if_id_pc4,   m_ipc + 32'd4);
    chk({tag, ".inst"},  if_id_inst,  m_inst);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    chk({tag, ".halt"},  {31'd0, halted},      {31'd0, m_halt});
    chk({tag, ".cnt"},   fetch_count, m_cnt);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".pc"},    pc, 32'd0);
    chk({tag, ".ipc"},   if_id_pc, 32'd0);
    chk({tag, ".ipc4"},  if_id_pc4, 32'd4);
    chk({tag, ".inst"},  if_id_inst, NOP);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, ".halt"},  {31'd0, halted}, 32'd0);
    chk({tag, ".cnt"},   fetch_count, 32'd0);
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] w, m2_orig;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == ECALL || w == EBREAK) w = w ^ 32'h100;
      mem[i] = w;
    end
    mem[0] = 32'h00108093; mem[1] = 32'h00420213;
    mem[2] = 32'h001282b3; mem[3] = 32'h00430333;
    mem[4] = 32'h00500393; mem[5] = 32'h00600413;

    tbl[0]  = '{0, 0, 0,        4, 0,  mem[0], 1, 1};
    tbl[1]  = '{0, 0, 0,        8, 4,  mem[1], 1, 2};
    tbl[2]  = '{0, 0, 0,       12, 8,  mem[2], 1, 3};
    tbl[3]  = '{0, 0, 0,       16, 12, mem[3], 1, 4};
    tbl[4]  = '{0, 1, 32'd4,    4, 12, NOP,    0, 4};
    tbl[5]  = '{0, 0, 0,        8, 4,  mem[1], 1, 5};
    tbl[6]  = '{1, 0, 0,        8, 4,  mem[1], 1, 5};
    tbl[7]  = '{1, 0, 0,        8, 4,  mem[1], 1, 5};
    tbl[8]  = '{1, 0, 0,        8, 4,  mem[1], 1, 5};
    tbl[9]  = '{0, 0, 0,       12, 8,  mem[2], 1, 6};
    tbl[10] = '{1, 1, 32'h12,  16, 8,  NOP,    0, 6};
    tbl[11] = '{0, 0, 0,       20, 16, mem[4], 1, 7};

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Directed table: straight line, stall, redirect under stall.
    for (int i = 0; i < 12; i++) begin
      stall = tbl[i].stall; redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
      tick();
      chk($sformatf("tbl%0d.pc", i),    pc, tbl[i].pc);
      chk($sformatf("tbl%0d.ipc", i),   if_id_pc, tbl[i].ipc);
      chk($sformatf("tbl%0d.ipc4", i),  if_id_pc4, tbl[i].ipc + 32'd4);
      chk($sformatf("tbl%0d.inst", i),  if_id_inst, tbl[i].inst);
      chk($sformatf("tbl%0d.valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].valid});
      chk($sformatf("tbl%0d.halt", i),  {31'd0, halted}, 32'd0);
      chk($sformatf("tbl%0d.cnt", i),   fetch_count, tbl[i].cnt);
    end
    stall = 1'b0; redirect_valid = 1'b0;

    // Halt on ECALL at word 2, then recover via redirect to 0.
    m2_orig = mem[2];
    mem[2] = ECALL;
    redirect_valid = 1'b1; redirect_target = 32'd0; tick(); check_model("h_redir");
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    chk("h_inst",  if_id_inst, ECALL);
    chk("h_valid", {31'd0, if_id_valid}, 32'd1);
    chk("h_halt",  {31'd0, halted}, 32'd1);
    chk("h_pc",    pc, 32'd8);
    tick(); tick();
    chk("h_bub_valid", {31'd0, if_id_valid}, 32'd0);
    chk("h_bub_inst",  if_id_inst, NOP);
    chk("h_bub_pc",    pc, 32'd8);
    check_model("h_bub");
    redirect_valid = 1'b1; redirect_target = 32'd0; tick();
    chk("h_clear", {31'd0, halted}, 32'd0);
    redirect_valid = 1'b0; tick();
    chk("h_restart_inst", if_id_inst, mem[0]);
    check_model("h_restart");

    // Wrap / alias at the top of the address space.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; tick();
    chk("w_addr", {26'd0, imem_addr}, 32'h3F);
    redirect_valid = 1'b0; tick();
    chk("w_ipc",  if_id_pc, 32'hFFFF_FFFC);
    chk("w_ipc4", if_id_pc4, 32'd0);
    chk("w_pc",   pc, 32'd0);
    check_model("wrap");

    // Async reset pulsed between edges while halted.
    redirect_valid = 1'b1; redirect_target = 32'd8; tick();
    redirect_valid = 1'b0; tick();
    chk("ar_pre_halt", {31'd0, halted}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset("areset");
    m_reset();
    mem[2] = m2_orig;
    #1 rst = 1'b0;
    tick();
    chk("ar_first_inst", if_id_inst, mem[0]);
    check_model("ar_first");

    // Randomized run against the reference model; a few halts are planted.
    mem[20] = ECALL; mem[41] = EBREAK;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_target = ($urandom_range(0, 1) == 1) ? $urandom : {24'd0, 8'($urandom)};
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the rVProc core. It owns the program counter, drives the word address of the combinational instruction memory, and registers the returned instruction into the IF/ID pipeline register. It sits directly upstream of the instruction memory and directly upstream of the decode stage. It handles stall, branch/jump redirect and ECALL/EBREAK halt.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 6, instruction-memory word-address width.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2].
- imem_data  in  32  instruction returned combinationally for imem_addr in the same cycle.
- stall  in  1  hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump from downstream.
- redirect_target  in  32  new PC; bits [1:0] forced to 0.
- pc  out  32  current fetch PC.
- if_id_pc  out  32  PC of the registered instruction.
- if_id_pc4  out  32  if_id_pc + 4, modulo 2^32.
- if_id_inst  out  32  registered instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- halted  out  1  high while in HALT.
- fetch_count  out  32  number of instructions captured with valid=1.

## Operation
- Reset (async, immediate): pc=RESET_PC; if_id_pc=0; if_id_pc4=4; if_id_inst=NOP_INST; if_id_valid=0; fetch_count=0; state=RUN; halted=0.
- States: RUN, HALT. The halted output is the registered state==HALT.
- RUN, per cycle, in priority order:
  - redirect_valid: pc <= {redirect_target[31:2],2'b00}; IF/ID <= bubble (inst=NOP_INST, valid=0, pc/pc4 held). Redirect overrides a simultaneous stall.
  - stall: pc, IF/ID and fetch_count are held.
  - Otherwise: IF/ID <= {pc, pc+4, imem_data, valid=1}; fetch_count += 1.
    - If imem_data is 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK), pc is held and the state becomes HALT.
    - Else pc <= pc+4.
- HALT, per cycle:
  - redirect_valid: handled as in RUN and the state returns to RUN. This covers an older mispredicted branch resolving after a wrong-path ECALL.
  - stall without redirect: everything is held.
  - Otherwise: IF/ID <= bubble; pc held; fetch_count held.
- Arithmetic: pc and if_id_pc4 wrap modulo 2^32; fetch_count wraps modulo 2^32.
- Addressing: imem_addr ignores pc[1:0] and pc bits above ADDR_W+1. The memory therefore aliases every 2^(ADDR_W+2) bytes (256 bytes at default). This is not an error.
- No X propagation: all IF/ID fields are defined from reset onward.

## Timing
- imem_addr is combinational from the pc register. The instruction is sampled on the same edge that advances pc.
- Latency: an instruction at PC p appears on if_id_* one cycle after pc==p, provided that cycle is not stalled or redirected.
- Redirect penalty: one bubble. The target instruction is captured on the second edge after redirect_valid is sampled.
- Stall is level-sensitive, with no limit on length. Deasserting it resumes on the next edge with no lost or duplicated instruction.
- Reset asserted mid-operation discards IF/ID contents and the HALT state. The first valid capture occurs on the first rising edge after rst deasserts.

## Test plan
- Straight line: memory words 0..3 hold 32'h00108093, 32'h00420213, 32'h001282b3, 32'h00430333; release reset with no stall -> if_id_inst follows those words on edges 1..4, if_id_pc = 0,4,8,12, if_id_pc4 = 4,8,12,16, fetch_count = 4.
- Stall: assert stall for 3 cycles while pc=8 -> pc stays 8, IF/ID holds the pc=4 instruction, fetch_count unchanged; on release, 32'h001282b3 is captured with if_id_pc=8.
- Redirect: redirect_valid with target 32'h0000_0012 while stall=1 -> pc=32'h10, one cycle with if_id_valid=0 and if_id_inst=32'h00000013, then the instruction at word 4 is captured.
- Halt: word 2 = 32'h00000073 -> captured with valid=1, halted=1 on the following cycle, pc stuck at 8, bubbles thereafter. A later redirect to 0 clears halted and fetching restarts at word 0.
- Wrap/alias: redirect to 32'hFFFF_FFFC -> imem_addr=6'h3F, capture gives if_id_pc4=0, next pc=0.
- Async reset mid-run: pulse rst between edges while in HALT -> outputs take their reset values immediately with no clock edge, and halted=0.
